// File: rtl/seq_chunk_adder_pkg.sv
// ---------------------------------------------------------------------------
// seq_adder_pkg
// Shared definitions for the sequential chunked adder:
//   - state_t   : controller states (IDLE / RUN / DONE)
//   - DEF_WIDTH : default operand width
//   - DEF_CHUNK : default bits added per cycle
//   - cfg_ok()  : elaboration-time legality check of a WIDTH/CHUNK pair
// ---------------------------------------------------------------------------
package seq_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // WIDTH must split into a whole number of CHUNK-bit slices.
  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder_if
// Operand and result handshake bundle of the sequential chunked adder.
//   operand side : in_valid, in_ready, a, b, cin (+ sub with SEQ_ADDER_SUB_EN)
//   result side  : out_valid, out_ready, sum, cout, ovf
// Modports:
//   master : producer of operands / consumer of results
//   slave  : the adder
// Optional macro: SEQ_ADDER_SUB_EN adds the 'sub' select.
// ---------------------------------------------------------------------------
interface seq_chunk_adder_if #(
  parameter int WIDTH = seq_adder_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SEQ_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SEQ_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif

endinterface

// File: rtl/seq_chunk_adder_chunk.sv
// ---------------------------------------------------------------------------
// chunk_adder
// Combinational CHUNK-bit ripple-carry adder slice.
//   a, b  : CHUNK-bit operands
//   ci    : carry in
//   s     : CHUNK-bit sum
//   co    : carry out of the slice MSB
//   c_msb : carry into the slice MSB (signed-overflow term on the top slice)
// ---------------------------------------------------------------------------
module chunk_adder #(
  parameter int CHUNK = seq_adder_pkg::DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  always_comb begin
    logic [CHUNK:0] c;
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co    = c[CHUNK];
    c_msb = c[CHUNK-1];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder
// Multi-cycle adder: a + b + cin computed CHUNK bits per clock, LS chunk
// first, through a carry register. One chunk_adder slice is reused every
// cycle, so the critical path is one CHUNK-bit ripple regardless of WIDTH.
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   io  : seq_chunk_adder_if.slave (operand and result handshakes)
// Latency: accept on edge E, out_valid high after edge E+WIDTH/CHUNK.
// Optional macro: SEQ_ADDER_SUB_EN enables a - b via io.sub.
// ---------------------------------------------------------------------------
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic              clk,
  input  logic              rst,
  seq_chunk_adder_if.slave  io
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
  end

  state_t state_q, state_d;

  logic [NCHUNK-1:0][CHUNK-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]                cnt_q;
  logic                         carry_q;
  logic                         cout_q, ovf_q;

  logic                         accept, last;
  logic [WIDTH-1:0]             b_in;
  logic                         c_in;
  logic [CHUNK-1:0]             ch_s;
  logic                         ch_co, ch_cm;

  // Subtraction folds into the add path: invert b at capture, force carry 1.
`ifdef SEQ_ADDER_SUB_EN
  assign b_in = io.sub ? ~io.b : io.b;
  assign c_in = io.sub | io.cin;
`else
  assign b_in = io.b;
  assign c_in = io.cin;
`endif

  assign io.in_ready  = (state_q == IDLE) & ~rst;
  assign io.out_valid = (state_q == DONE);
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;

  assign accept = io.in_valid & io.in_ready;
  assign last   = (cnt_q == CW'(NCHUNK - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[cnt_q]),
    .b     (b_q[cnt_q]),
    .ci    (carry_q),
    .s     (ch_s),
    .co    (ch_co),
    .c_msb (ch_cm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)       state_d = RUN;
      RUN:     if (last)         state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // sum/cout/ovf are only written in RUN, so they hold through DONE and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q     <= io.a;
          b_q     <= b_in;
          carry_q <= c_in;
          cnt_q   <= '0;
        end
        RUN: begin
          sum_q[cnt_q] <= ch_s;
          carry_q      <= ch_co;
          cnt_q        <= cnt_q + CW'(1);
          if (last) begin
            cout_q <= ch_co;
            ovf_q  <= ch_co ^ ch_cm;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
